// File: rtl/srrc_sym_fir.sv
// srrc_sym_fir: symmetric SRRC FIR with pre-add, runtime coefficients, rounding and saturation
module srrc_sym_fir #(
  parameter int WIDTH = 18,
  parameter int COEF_W = 18,
  parameter int NTAPS = 17,
  parameter int AW = $clog2((NTAPS + 1) / 2)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sam_en,
  input  logic signed [WIDTH-1:0]  in,
  input  logic                     coef_wr,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     sat_clr,
  output logic signed [WIDTH-1:0]  out,
  output logic                     out_valid,
  output logic                     sat_flag
);
  localparam int NU = (NTAPS + 1) / 2;
  localparam int PW = WIDTH + 1 + COEF_W;
  localparam int SW = PW + $clog2(NU);
  localparam logic signed [SW:0] HALF = (SW + 1)'(1) <<< (COEF_W - 2);
  localparam logic signed [SW:0] YMAX = (SW + 1)'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [SW:0] YMIN = -YMAX - (SW + 1)'(1);
  localparam int DEF [9] = '{314, -2115, -5743, -6936, -719, 15367, 37897, 57966, 66023};
  localparam bit USE_DEF = (NTAPS == 17) && (COEF_W == 18);
  function automatic logic signed [COEF_W-1:0] def_coef(input int k);
    return USE_DEF ? COEF_W'(DEF[k % 9]) : (k == NU - 1) ? {1'b0, {(COEF_W - 1){1'b1}}} : '0;
  endfunction
  logic signed [WIDTH-1:0]  x_q [NTAPS];
  logic signed [WIDTH:0]    p_q [NU];
  logic signed [PW-1:0]     m_q [NU];
  logic signed [COEF_W-1:0] c_q [NU];
  logic signed [SW-1:0]     acc_q, acc_d;
  logic signed [SW:0]       rnd_d;
  logic signed [WIDTH-1:0]  y_d, out_q;
  logic                     hi_d, lo_d, out_valid_q, sat_q;
  logic [3:0]               v_q;
  always_comb begin
    acc_d = '0;
    for (int k = 0; k < NU; k++) acc_d = acc_d + SW'(m_q[k]);
    rnd_d = ((SW + 1)'(acc_q) + HALF) >>> (COEF_W - 1);
    hi_d = rnd_d > YMAX;
    lo_d = rnd_d < YMIN;
    y_d = hi_d ? YMAX[WIDTH-1:0] : lo_d ? YMIN[WIDTH-1:0] : rnd_d[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
      for (int k = 0; k < NU; k++) begin
        p_q[k] <= '0;
        m_q[k] <= '0;
        c_q[k] <= def_coef(k);
      end
      acc_q <= '0;
      v_q <= '0;
      out_q <= '0;
      out_valid_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      if (sam_en) begin
        x_q[0] <= in;
        for (int k = 1; k < NTAPS; k++) x_q[k] <= x_q[k-1];
      end
      // centre tap has no mirror partner; the rest pre-add their symmetric pair
      for (int k = 0; k < NU; k++) begin
        p_q[k] <= (k == NU - 1) ? (WIDTH + 1)'(x_q[k])
                                : (WIDTH + 1)'(x_q[k]) + (WIDTH + 1)'(x_q[NTAPS-1-k]);
        m_q[k] <= PW'(p_q[k]) * PW'(c_q[k]);
      end
      if (coef_wr && ({1'b0, coef_addr} < (AW + 1)'(NU))) c_q[coef_addr] <= coef_data;
      acc_q <= acc_d;
      v_q <= {v_q[2:0], sam_en};
      out_valid_q <= v_q[3];
      if (v_q[3]) out_q <= y_d;
      sat_q <= (v_q[3] && (hi_d || lo_d)) || (sat_q && !sat_clr);
    end
  end
  assign out = out_q;
  assign out_valid = out_valid_q;
  assign sat_flag = sat_q;
endmodule

// File: tb/tb_srrc_sym_fir.sv
// tb_srrc_sym_fir: directed table-driven checks of the symmetric SRRC FIR
module tb_srrc_sym_fir;
  typedef struct {
    int din;
    int exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sam_en = 1'b0;
  logic coef_wr = 1'b0;
  logic sat_clr = 1'b0;
  logic signed [17:0] in_s = '0;
  logic [3:0] coef_addr = '0;
  logic signed [17:0] coef_data = '0;
  logic signed [17:0] out_s;
  logic out_valid, sat_flag;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int cap_v[$];
  int cap_c[$];
  vec_t imp[17];
  int e_half[9] = '{314, -2115, -5743, -6936, -719, 15367, 37897, 57966, 66022};
  always #5 clk = ~clk;
  srrc_sym_fir dut (
    .clk(clk), .reset(reset), .sam_en(sam_en), .in(in_s),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .sat_clr(sat_clr), .out(out_s), .out_valid(out_valid), .sat_flag(sat_flag)
  );
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    if (out_valid) begin
      cap_v.push_back(int'(out_s));
      cap_c.push_back(cyc);
    end
  endtask
  task automatic samp(input logic en, input int v);
    sam_en = en;
    in_s = 18'(v);
    tick();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) samp(1'b0, 0);
  endtask
  task automatic wr(input int a, input int d);
    coef_wr = 1'b1;
    coef_addr = 4'(a);
    coef_data = 18'(d);
    samp(1'b0, 0);
    coef_wr = 1'b0;
  endtask
  function automatic int cap_at(input int k);
    return (k < cap_v.size()) ? cap_v[k] : -999999;
  endfunction
  task automatic run_impulse(output int acc);
    cap_v.delete();
    cap_c.delete();
    samp(1'b1, 131071);
    acc = cyc;
    for (int k = 1; k < 17; k++) samp(1'b1, 0);
    idle(8);
  endtask
  initial begin
    int acc, held, idx, n0;
    for (int k = 0; k < 17; k++) begin
      imp[k].din = (k == 0) ? 131071 : 0;
      imp[k].exp = e_half[(k < 9) ? k : 16 - k];
    end
    // reset state
    sam_en = 1'b1;
    in_s = 18'sd5000;
    tick();
    tick();
    chk("rst_out", int'(out_s), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sat", int'(sat_flag), 0);
    reset = 1'b0;
    idle(3);
    chk("rst_idle_valid", cap_v.size(), 0);
    // impulse at full rate with default coefficients
    run_impulse(acc);
    chk("imp_count", cap_v.size(), 17);
    chk("imp_latency", (cap_c.size() > 0) ? cap_c[0] - acc : -1, 4);
    chk("imp_span", (cap_c.size() == 17) ? cap_c[16] - cap_c[0] : -1, 16);
    for (int k = 0; k < 17; k++) chk($sformatf("imp_out[%0d]", k), cap_at(k), imp[k].exp);
    // impulse sampled every 4th clock: out must hold between pulses
    held = imp[16].exp;
    idx = 0;
    for (int k = 0; k < 19; k++)
      for (int j = 0; j < 4; j++) begin
        samp(j == 0 && k < 17, (k < 17) ? imp[k].din : 0);
        if (out_valid) begin
          held = (idx < 17) ? imp[idx].exp : 0;
          chk($sformatf("imp4_out[%0d]", idx), int'(out_s), held);
          idx++;
        end else chk("imp4_hold", int'(out_s), held);
      end
    chk("imp4_count", idx, 17);
    // DC 32768 settles to the scaled coefficient sum
    cap_v.delete();
    for (int k = 0; k < 30; k++) samp(1'b1, 32768);
    idle(6);
    chk("dc_count", cap_v.size(), 30);
    for (int k = 17; k < 30; k++) chk($sformatf("dc_out[%0d]", k), cap_at(k), 64521);
    chk("dc_sat", int'(sat_flag), 0);
    // full-scale DC saturates; set beats a coincident clear; flag is sticky
    for (int k = 0; k < 25; k++) samp(1'b1, 131071);
    chk("sat_out", int'(out_s), 131071);
    chk("sat_flag_set", int'(sat_flag), 1);
    sat_clr = 1'b1;
    samp(1'b1, 131071);
    sat_clr = 1'b0;
    chk("sat_set_wins", int'(sat_flag), 1);
    for (int k = 0; k < 25; k++) samp(1'b1, 0);
    idle(6);
    chk("sat_drain_out", int'(out_s), 0);
    chk("sat_sticky", int'(sat_flag), 1);
    sat_clr = 1'b1;
    samp(1'b0, 0);
    sat_clr = 1'b0;
    chk("sat_cleared", int'(sat_flag), 0);
    // runtime coefficient writes, out-of-range writes ignored
    for (int a = 1; a < 9; a++) wr(a, 0);
    wr(0, 65536);
    for (int a = 9; a < 16; a++) wr(a, 12345);
    run_impulse(acc);
    chk("cw_count", cap_v.size(), 17);
    for (int k = 0; k < 17; k++)
      chk($sformatf("cw_out[%0d]", k), cap_at(k), (k == 0 || k == 16) ? 65536 : 0);
    // write lands after the impulse's first product: only later products see it
    cap_v.delete();
    samp(1'b1, 131071);
    samp(1'b1, 0);
    coef_wr = 1'b1;
    coef_addr = 4'd0;
    coef_data = 18'sd32768;
    samp(1'b1, 0);
    coef_wr = 1'b0;
    for (int k = 3; k < 17; k++) samp(1'b1, 0);
    idle(8);
    chk("mid_count", cap_v.size(), 17);
    chk("mid_first", cap_at(0), 65536);
    chk("mid_mid", cap_at(8), 0);
    chk("mid_last", cap_at(16), 32768);
    // saturate again, then reset 2 clocks after an accepted sample
    wr(0, 131071);
    for (int k = 0; k < 25; k++) samp(1'b1, 131071);
    chk("pre_rst_sat", int'(sat_flag), 1);
    for (int k = 0; k < 3; k++) begin
      samp(1'b1, 0);
      idle(3);
    end
    samp(1'b1, 131071);
    samp(1'b0, 0);
    reset = 1'b1;
    sam_en = 1'b1;
    coef_wr = 1'b1;
    sat_clr = 1'b0;
    tick();
    reset = 1'b0;
    sam_en = 1'b0;
    coef_wr = 1'b0;
    chk("mrst_out", int'(out_s), 0);
    chk("mrst_valid", int'(out_valid), 0);
    chk("mrst_sat", int'(sat_flag), 0);
    n0 = cap_v.size();
    idle(10);
    chk("mrst_no_valid", cap_v.size() - n0, 0);
    run_impulse(acc);
    chk("mrst_imp_count", cap_v.size(), 17);
    for (int k = 0; k < 17; k++) chk($sformatf("mrst_imp[%0d]", k), cap_at(k), imp[k].exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
